// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// serial_adder_ctrl_if: request/result handshake plus the external full-adder
// bit lanes for the bit-serial adder controller. Revision 1.0.
interface serial_adder_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         cin_in;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic [N-1:0] sum_out;
  logic         cout_out;
  logic         busy;
  logic         done;

  // master is everything around the controller: requester and full adder
  modport master (
    output start, a_in, b_in, cin_in, fa_sum, fa_cout,
    input  fa_a, fa_b, fa_cin, sum_out, cout_out, busy, done
  );

  modport slave (
    input  start, a_in, b_in, cin_in, fa_sum, fa_cout,
    output fa_a, fa_b, fa_cin, sum_out, cout_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// serial_adder_ctrl: bit-serial N-bit adder around an external 1-bit full
// adder, LSB first, start/busy/done handshake. Revision 1.0.
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic          carry;
  logic [CW-1:0] count;
  logic [N-1:0]  sum_reg;
  logic          cout_reg;
  logic          in_shift;
  logic          accept;

  assign in_shift = (state == SHIFT);
  // start is only honoured between operations; DONE allows back-to-back adds
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = SHIFT;
      SHIFT:   if (count == LAST) state_n = DONE;
      DONE:    state_n = bus.start ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.a_in;
      b_sh    <= bus.b_in;
      carry   <= bus.cin_in;
      count   <= '0;
      sum_reg <= '0;
    end else if (in_shift) begin
      sum_reg <= {bus.fa_sum, sum_reg[N-1:1]};
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry   <= bus.fa_cout;
      count   <= count + 1'b1;
      if (count == LAST) cout_reg <= bus.fa_cout;
    end
  end

  assign bus.fa_a     = in_shift & a_sh[0];
  assign bus.fa_b     = in_shift & b_sh[0];
  assign bus.fa_cin   = in_shift & carry;
  assign bus.sum_out  = sum_reg;
  assign bus.cout_out = cout_reg;
  assign bus.busy     = in_shift;
  assign bus.done     = (state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// tb_serial_adder_ctrl: vector table, random adds against an arithmetic
// model, and hand sequences for re-start, abort, back-to-back and idle.
module tb_serial_adder_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.N(N)) sif ();

  // behavioural full adder
  assign sif.fa_sum  = sif.fa_a ^ sif.fa_b ^ sif.fa_cin;
  assign sif.fa_cout = (sif.fa_a & sif.fa_b) | (sif.fa_a & sif.fa_cin) | (sif.fa_b & sif.fa_cin);

  serial_adder_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[7];

  // Issues one add from IDLE and observes N+4 cycles after the accepting edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        output int first_done, output int busy_cnt, output int done_cnt,
                        output logic [N-1:0] s, output logic co,
                        output logic [N-1:0] fa_av, output logic [N-1:0] fa_bv,
                        output logic cin0);
    sif.start  = 1'b1;
    sif.a_in   = a;
    sif.b_in   = b;
    sif.cin_in = c;
    step();
    sif.start  = 1'b0;
    sif.a_in   = N'($urandom);
    sif.b_in   = N'($urandom);
    sif.cin_in = 1'($urandom);
    first_done = -1;
    busy_cnt   = 0;
    done_cnt   = 0;
    s          = 'x;
    co         = 1'bx;
    fa_av      = '0;
    fa_bv      = '0;
    cin0       = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      if (sif.busy) begin
        busy_cnt++;
        if (busy_cnt <= N) begin
          fa_av[busy_cnt-1] = sif.fa_a;
          fa_bv[busy_cnt-1] = sif.fa_b;
        end
        if (busy_cnt == 1) cin0 = sif.fa_cin;
      end
      if (sif.done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = i;
          s  = sif.sum_out;
          co = sif.cout_out;
        end
      end
      step();
    end
  endtask

  initial begin
    int fd, bc, dc;
    logic [N-1:0] s, fav, fbv;
    logic co, c0;
    logic [N:0] model;
    logic [N-1:0] ra, rb;
    logic rc;
    int d1, d2;
    logic [N-1:0] s1, s2;
    logic co1, co2;

    vecs[0] = '{a: 8'd23,  b: 8'd45,  cin: 1'b0, es: 8'd68,  ec: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   cin: 1'b0, es: 8'd0,   ec: 1'b1};
    vecs[2] = '{a: 8'd255, b: 8'd255, cin: 1'b1, es: 8'd255, ec: 1'b1};
    vecs[3] = '{a: 8'd100, b: 8'd27,  cin: 1'b0, es: 8'd127, ec: 1'b0};
    vecs[4] = '{a: 8'd200, b: 8'd100, cin: 1'b0, es: 8'd44,  ec: 1'b1};
    vecs[5] = '{a: 8'd0,   b: 8'd0,   cin: 1'b1, es: 8'd1,   ec: 1'b0};
    vecs[6] = '{a: 8'd128, b: 8'd128, cin: 1'b0, es: 8'd0,   ec: 1'b1};

    sif.start = 1'b0; sif.a_in = '0; sif.b_in = '0; sif.cin_in = 1'b0;
    step(); step();
    check("reset_busy", 32'(sif.busy), 0);
    check("reset_done", 32'(sif.done), 0);
    check("reset_sum", 32'(sif.sum_out), 0);
    check("reset_cout", 32'(sif.cout_out), 0);
    check("reset_fa", 32'({sif.fa_a, sif.fa_b, sif.fa_cin}), 0);
    rst = 1'b0;
    step();

    foreach (vecs[v]) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, fd, bc, dc, s, co, fav, fbv, c0);
      check($sformatf("vec%0d_sum", v), 32'(s), 32'(vecs[v].es));
      check($sformatf("vec%0d_cout", v), 32'(co), 32'(vecs[v].ec));
      check($sformatf("vec%0d_done_lat", v), 32'(fd), N);
      check($sformatf("vec%0d_busy_cycles", v), 32'(bc), N);
      check($sformatf("vec%0d_done_pulses", v), 32'(dc), 1);
      check($sformatf("vec%0d_fa_a_bits", v), 32'(fav), 32'(vecs[v].a));
      check($sformatf("vec%0d_fa_b_bits", v), 32'(fbv), 32'(vecs[v].b));
      check($sformatf("vec%0d_fa_cin0", v), 32'(c0), 32'(vecs[v].cin));
    end

    for (int r = 0; r < 30; r++) begin
      ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      run_op(ra, rb, rc, fd, bc, dc, s, co, fav, fbv, c0);
      check($sformatf("rand%0d_result", r), 32'({co, s}), 32'(model));
      check($sformatf("rand%0d_done_lat", r), 32'(fd), N);
    end

    // start re-pulsed during SHIFT must be ignored
    sif.start = 1'b1; sif.a_in = 8'd23; sif.b_in = 8'd45; sif.cin_in = 1'b0;
    step();
    sif.start = 1'b0;
    fd = -1; dc = 0; s = 'x; co = 1'bx;
    for (int i = 0; i < N + 4; i++) begin
      if (i == 2) begin sif.start = 1'b1; sif.a_in = 8'd1; sif.b_in = 8'd1; end
      if (i == 3) sif.start = 1'b0;
      if (sif.done) begin
        dc++;
        if (fd < 0) begin fd = i; s = sif.sum_out; co = sif.cout_out; end
      end
      step();
    end
    check("repulse_sum", 32'(s), 68);
    check("repulse_cout", 32'(co), 0);
    check("repulse_done_lat", 32'(fd), N);
    check("repulse_done_pulses", 32'(dc), 1);

    // reset at the fourth SHIFT edge aborts the add
    sif.start = 1'b1; sif.a_in = 8'd23; sif.b_in = 8'd45; sif.cin_in = 1'b0;
    step();
    sif.start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("abort_busy", 32'(sif.busy), 0);
    check("abort_done", 32'(sif.done), 0);
    check("abort_sum", 32'(sif.sum_out), 0);
    check("abort_cout", 32'(sif.cout_out), 0);
    check("abort_fa", 32'({sif.fa_a, sif.fa_b, sif.fa_cin}), 0);
    rst = 1'b0;
    dc = 0; bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (sif.done) dc++;
      if (sif.busy) bc++;
      step();
    end
    check("abort_no_done", 32'(dc), 0);
    check("abort_no_busy", 32'(bc), 0);

    // start held high: back-to-back adds, operands swapped in the DONE cycle
    sif.start = 1'b1; sif.a_in = 8'd100; sif.b_in = 8'd27; sif.cin_in = 1'b0;
    step();
    d1 = -1; d2 = -1; dc = 0;
    s1 = 'x; s2 = 'x; co1 = 1'bx; co2 = 1'bx;
    for (int i = 0; i < 2 * N + 6; i++) begin
      if (sif.done) begin
        dc++;
        if (d1 < 0) begin
          d1 = i; s1 = sif.sum_out; co1 = sif.cout_out;
          sif.a_in = 8'd200; sif.b_in = 8'd100;
        end else if (d2 < 0) begin
          d2 = i; s2 = sif.sum_out; co2 = sif.cout_out;
          sif.start = 1'b0;
        end
      end
      step();
    end
    sif.start = 1'b0;
    check("b2b_first_lat", 32'(d1), N);
    check("b2b_spacing", 32'(d2 - d1), N + 1);
    check("b2b_first_result", 32'({co1, s1}), 127);
    check("b2b_second_result", 32'({co2, s2}), 256 + 44);
    check("b2b_done_pulses", 32'(dc), 2);

    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle%0d_fa", i), 32'({sif.fa_a, sif.fa_b, sif.fa_cin}), 0);
      check($sformatf("idle%0d_status", i), 32'({sif.busy, sif.done}), 0);
      check($sformatf("idle%0d_result", i), 32'({sif.cout_out, sif.sum_out}), 256 + 44);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
